im_loader: RTL and testbench

- Boot-time program loader: the write-side initiator for the 1024 x 32 instruction memory.
- Accepts a byte stream (length header, then little-endian instruction words) over a valid/ready handshake.
- Assembles each 32-bit word and drives the instruction memory write port (imWrite, imWrDat, imWrDat_addr) with one write per word from address 0 upward.
- Holds the processor via busy until the image is complete.

---
 rtl/im_pkg.sv | 24 ++
 rtl/im_loader_if.sv | 24 ++
 rtl/im_word_packer.sv | 42 ++++
 rtl/im_loader.sv | 105 ++++++++++
 tb/tb_im_loader.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/im_pkg.sv
// Shared definitions for the instruction-memory loader: geometry, FSM
// encoding and the image-header legality check.
package im_pkg;

    localparam int IM_ADDR_W = 10;
    localparam int IM_DATA_W = 32;
    localparam int IM_DEPTH  = 1 << IM_ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loaderState_t;

    // A header is usable when it names at least one word and fits the memory.
    function automatic logic headerOk(input logic [15:0] cnt, input int addrW);
        return (cnt != 16'd0) && (32'(cnt) <= (32'd1 << addrW));
    endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
interface im_loader_if
    import im_pkg::*;
#(
    parameter int ADDR_W = IM_ADDR_W,
    parameter int DATA_W = IM_DATA_W
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imWrite;
    logic [DATA_W-1:0] imWrDat;
    logic [ADDR_W-1:0] imWrDat_addr;

    modport master (
        input  byte_in, byte_valid,
        output byte_ready, imWrite, imWrDat, imWrDat_addr
    );

    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, imWrite, imWrDat, imWrDat_addr
    );
endinterface

// File: rtl/im_word_packer.sv
// Little-endian byte-to-word assembler; wordFull flags the load that
// completes a word, with word already carrying that final byte.
module im_word_packer
    import im_pkg::*;
#(
    parameter int DATA_W = IM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [7:0]        byteIn,
    output logic              wordFull,
    output logic [DATA_W-1:0] word
);
    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [IDX_W-1:0]  byteIdx;
    logic [DATA_W-1:0] shiftReg;
    logic              byteLast;

    assign byteLast = (byteIdx == IDX_W'(BYTES - 1));
    assign wordFull = load & byteLast;

    always_comb begin
        word = shiftReg;
        if (load) word[8*byteIdx +: 8] = byteIn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byteIdx  <= '0;
            shiftReg <= '0;
        end else if (clear) begin
            byteIdx  <= '0;
        end else if (load) begin
            shiftReg <= word;
            byteIdx  <= byteLast ? '0 : byteIdx + 1'b1;
        end
    end
endmodule

// File: rtl/im_loader.sv
// Boot-time loader: parses a 16-bit word-count header, then writes each
// assembled little-endian word to instruction memory from address 0 upward.
module im_loader
    import im_pkg::*;
#(
    parameter int ADDR_W = IM_ADDR_W,
    parameter int DATA_W = IM_DATA_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    im_loader_if.master bus
);
    loaderState_t      state, nextState;
    logic              xfer, wordFull, lastWord, headerGood, packClear, packLoad;
    logic [7:0]        countLo;
    logic [15:0]       wordCount, headerCount, lastIdx;
    logic [ADDR_W-1:0] addr, wrAddrQ;
    logic [DATA_W-1:0] packWord, wrDatQ;

    assign xfer        = bus.byte_valid & bus.byte_ready;
    assign headerCount = {bus.byte_in, countLo};
    assign headerGood  = headerOk(headerCount, ADDR_W);
    assign lastIdx     = wordCount - 16'd1;
    assign lastWord    = (16'(addr) == lastIdx);
    assign packClear   = (state == ST_LEN_HI) || (state == ST_WRITE);
    assign packLoad    = (state == ST_DATA) && xfer;

    im_word_packer #(.DATA_W(DATA_W)) packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (packClear),
        .load     (packLoad),
        .byteIn   (bus.byte_in),
        .wordFull (wordFull),
        .word     (packWord)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: if (start) nextState = ST_LEN_LO;
            ST_LEN_LO: if (xfer) nextState = ST_LEN_HI;
            ST_LEN_HI: if (xfer) nextState = headerGood ? ST_DATA : ST_ERR;
            ST_DATA:   if (wordFull) nextState = ST_WRITE;
            ST_WRITE:  nextState = lastWord ? ST_DONE : ST_DATA;
            default:   nextState = ST_IDLE;
        endcase
    end

    // Handshake and status are pure state decodes, so reset clears them at once.
    always_comb begin
        bus.byte_ready = 1'b0;
        bus.imWrite    = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        err            = 1'b0;
        case (state)
            ST_LEN_LO, ST_LEN_HI, ST_DATA: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
            end
            ST_WRITE: begin
                bus.imWrite = 1'b1;
                busy        = 1'b1;
            end
            ST_DONE: done = 1'b1;
            ST_ERR:  err  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countLo   <= '0;
            wordCount <= '0;
            addr      <= '0;
            wrAddrQ   <= '0;
            wrDatQ    <= '0;
        end else begin
            if ((state == ST_LEN_LO) && xfer) countLo <= bus.byte_in;
            if ((state == ST_LEN_HI) && xfer) begin
                wordCount <= headerCount;
                addr      <= '0;
            end
            // The final word leaves addr untouched, so it can never wrap.
            if ((state == ST_WRITE) && !lastWord) addr <= addr + 1'b1;
            if (wordFull) begin
                wrDatQ  <= packWord;
                wrAddrQ <= addr;
            end
        end
    end

    assign bus.imWrDat      = wrDatQ;
    assign bus.imWrDat_addr = wrAddrQ;
endmodule

// File: tb/tb_im_loader.sv
// Directed-sequence bench for im_loader with random data and random stalls,
// checked against an expected write list derived from each image.
module tb_im_loader;
    import im_pkg::*;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy, done, err;

    im_loader_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    im_loader #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int  vectors    = 0;
    int  miscompares = 0;
    int  readyViol  = 0;
    bit  abortSend  = 1'b0;
    wr_t capQ[$];

    // Every write pulse is recorded; the stream must be stalled while writing.
    always @(negedge clk) begin
        if (rst_n && bus.imWrite) begin
            capQ.push_back('{a: bus.imWrDat_addr, d: bus.imWrDat});
            if (bus.byte_ready) readyViol++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.byte_ready), 0);
        chk({tag, "_write"}, 32'(bus.imWrite), 0);
        chk({tag, "_dat"},   bus.imWrDat, 0);
        chk({tag, "_addr"},  32'(bus.imWrDat_addr), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_err"},   32'(err), 0);
    endtask

    task automatic sendBytes(input logic [7:0] bq[$], input bit stall, input int gapAt);
        bit acc;
        int guard;
        for (int i = 0; i < bq.size(); i++) begin
            acc   = 1'b0;
            guard = 0;
            while (!acc && !abortSend && guard <= 300) begin
                @(negedge clk);
                if (i == gapAt && guard < 20) bus.byte_valid = 1'b0;
                else bus.byte_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                bus.byte_in = bq[i];
                acc = bus.byte_valid && bus.byte_ready;
                guard++;
                @(posedge clk);
            end
            if (!acc && !abortSend) chk("byte_accept", 32'(acc), 1);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    // Runs one load: start pulse, byte stream, and a count of edges to done/err.
    task automatic doLoad(input logic [15:0] cnt, input logic [31:0] words[$],
                          input bit stall, input int gapAt, input bit pokeStart,
                          input int resetAfter, input int base, output int cycles);
        logic [7:0]  bq[$];
        logic [31:0] w;
        int          n;
        bq.push_back(cnt[7:0]);
        bq.push_back(cnt[15:8]);
        foreach (words[i]) begin
            w = words[i];
            for (int k = 0; k < 4; k++) bq.push_back(w[8*k +: 8]);
        end
        cycles = 0;
        @(negedge clk);
        start = 1'b1;
        fork
            begin
                @(negedge clk);
                start = 1'b0;
                if (pokeStart) begin
                    repeat (4) @(negedge clk);
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
            sendBytes(bq, stall, gapAt);
            begin
                do begin
                    @(posedge clk);
                    #1;
                    cycles++;
                end while (!done && !err && !abortSend && cycles < 20000);
            end
            if (resetAfter > 0) begin
                n = 0;
                while ((capQ.size() - base) < resetAfter && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                @(negedge clk);
                #1;
                rst_n     = 1'b0;
                abortSend = 1'b1;
                #1;
                checkIdleOutputs("midreset");
            end
        join
    endtask

    task automatic checkWrites(input string tag, input int base, input logic [31:0] words[$]);
        int bad;
        chk({tag, "_nwrites"}, 32'(capQ.size() - base), 32'(words.size()));
        bad = 0;
        for (int i = 0; i < words.size(); i++) begin
            if (base + i >= capQ.size()) begin
                bad++;
            end else if (words.size() <= 8) begin
                chk($sformatf("%s_addr%0d", tag, i), 32'(capQ[base+i].a), 32'(i));
                chk($sformatf("%s_dat%0d", tag, i), capQ[base+i].d, words[i]);
            end else if (32'(capQ[base+i].a) != 32'(i) || capQ[base+i].d != words[i]) begin
                bad++;
            end
        end
        if (words.size() > 8) chk({tag, "_badwords"}, 32'(bad), 0);
    endtask

    initial begin
        logic [31:0] none[$];
        logic [31:0] prog3[$];
        logic [31:0] one[$];
        logic [31:0] rnd[$];
        logic [31:0] big[$];
        int base, cyc;

        rst_n = 1'b0;
        start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'hA5;
        repeat (2) @(negedge clk);
        chk("idle_ready", 32'(bus.byte_ready), 0);
        chk("idle_busy", 32'(busy), 0);
        bus.byte_valid = 1'b0;

        // Reference three-instruction program with byte_valid held high
        prog3 = '{32'h0000_0013, 32'h0010_0093, 32'h0000_006F};
        base = capQ.size();
        doLoad(16'd3, prog3, 1'b0, -1, 1'b0, 0, base, cyc);
        chk("p3_latency", 32'(cyc), 18);
        checkWrites("p3", base, prog3);
        chk("p3_done", 32'(done), 1);
        chk("p3_busy", 32'(busy), 0);
        chk("p3_err", 32'(err), 0);

        // start during DATA must not disturb the load
        base = capQ.size();
        doLoad(16'd3, prog3, 1'b0, -1, 1'b1, 0, base, cyc);
        chk("poke_latency", 32'(cyc), 18);
        checkWrites("poke", base, prog3);

        // Illegal headers
        base = capQ.size();
        doLoad(16'h0000, none, 1'b0, -1, 1'b0, 0, base, cyc);
        chk("h0_err", 32'(err), 1);
        chk("h0_done", 32'(done), 0);
        chk("h0_busy", 32'(busy), 0);
        chk("h0_nwrites", 32'(capQ.size() - base), 0);
        base = capQ.size();
        doLoad(16'h0401, none, 1'b0, -1, 1'b0, 0, base, cyc);
        chk("h401_err", 32'(err), 1);
        chk("h401_nwrites", 32'(capQ.size() - base), 0);

        // Valid start after an error clears err
        one = '{$urandom()};
        base = capQ.size();
        doLoad(16'd1, one, 1'b0, -1, 1'b0, 0, base, cyc);
        chk("rec_err", 32'(err), 0);
        chk("rec_done", 32'(done), 1);
        checkWrites("rec", base, one);

        // Random data, random stalls and a 20-cycle gap before byte 3 of word 0
        for (int i = 0; i < 4; i++) rnd.push_back($urandom());
        base = capQ.size();
        doLoad(16'd4, rnd, 1'b1, 5, 1'b0, 0, base, cyc);
        chk("stall_done", 32'(done), 1);
        checkWrites("stall", base, rnd);

        // Full-capacity image
        for (int i = 0; i < IM_DEPTH; i++) big.push_back(32'(i));
        base = capQ.size();
        doLoad(16'h0400, big, 1'b0, -1, 1'b0, 0, base, cyc);
        chk("full_latency", 32'(cyc), 3 + 5 * IM_DEPTH);
        checkWrites("full", base, big);
        if (capQ.size() > 0) begin
            chk("full_lastaddr", 32'(capQ[capQ.size()-1].a), 32'h3FF);
            chk("full_lastdat", capQ[capQ.size()-1].d, 32'h0000_03FF);
        end

        // Reset in the middle of a 4-word image, then a one-word image
        base = capQ.size();
        doLoad(16'd4, rnd, 1'b0, -1, 1'b0, 2, base, cyc);
        chk("abort_nwrites", 32'(capQ.size() - base), 2);
        @(negedge clk);
        rst_n     = 1'b1;
        abortSend = 1'b0;
        one = '{32'h0000_0013};
        base = capQ.size();
        doLoad(16'd1, one, 1'b0, -1, 1'b0, 0, base, cyc);
        chk("after_rst_latency", 32'(cyc), 8);
        chk("after_rst_done", 32'(done), 1);
        checkWrites("after_rst", base, one);

        chk("ready_in_write", 32'(readyViol), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
